// File: rtl/cascade_counter_pkg.sv
// Shared constants for the cascaded counter: direction encoding and default geometry.
package cascade_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_STAGE_WIDTH = 2;
    localparam int DEFAULT_STAGE_COUNT = 2;

endpackage

// File: rtl/cascade_counter_stage.sv
// One digit of the cascaded counter: a P_STAGE_WIDTH-bit up/down register that
// steps on request and reports whether it sits at the terminal for the current direction.
module cascade_counter_stage
    import cascade_counter_pkg::*;
#(
    parameter int P_STAGE_WIDTH = DEFAULT_STAGE_WIDTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     clear,
    input  logic                     load,
    input  logic [P_STAGE_WIDTH-1:0] load_value,
    input  logic                     step,
    input  logic                     direction,
    output logic [P_STAGE_WIDTH-1:0] value,
    output logic                     terminal
);

    localparam logic [P_STAGE_WIDTH-1:0] ONE = P_STAGE_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= (direction == DIR_UP) ? value + ONE : value - ONE;
        end
    end

    // Terminal is direction-relative: all ones when counting up, zero when counting down.
    assign terminal = (direction == DIR_UP) ? (&value) : ~(|value);

endmodule

// File: rtl/cascade_counter.sv
// Cascaded up/down counter built from P_STAGE_COUNT digit stages, wrap or saturate.
// Define CASCADE_COUNTER_LOAD_EN to enable the load/load_value preload path.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int P_STAGE_WIDTH = DEFAULT_STAGE_WIDTH,
    parameter int P_STAGE_COUNT = DEFAULT_STAGE_COUNT,
    localparam int W = P_STAGE_WIDTH * P_STAGE_COUNT
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     param_cycle_en,
    input  logic                     param_direction,
    input  logic                     load,
    input  logic [W-1:0]             load_value,
    output logic [W-1:0]             counter,
    output logic                     counter_full,
    output logic                     counter_empty,
    output logic [P_STAGE_COUNT-1:0] stage_carry,
    output logic                     wrap_pulse,
    output logic                     halted
);

    logic [P_STAGE_COUNT-1:0] stage_term;
    logic [P_STAGE_COUNT-1:0] stage_step;
    logic [P_STAGE_COUNT:0]   lower_term;
    logic [W-1:0]             load_bus;
    logic                     load_act;
    logic                     count_ok;

`ifdef CASCADE_COUNTER_LOAD_EN
    assign load_act = load;
    assign load_bus = load_value;
`else
    logic unused_load;
    assign unused_load = ^{load, load_value};
    assign load_act    = 1'b0;
    assign load_bus    = '0;
`endif

    // Whole counter is at terminal exactly when every stage is; that drives saturation.
    assign lower_term[0] = 1'b1;
    assign halted        = ~param_cycle_en & lower_term[P_STAGE_COUNT];
    assign count_ok      = en & ~reset & ~load_act & ~halted;

    genvar k;
    generate
        for (k = 0; k < P_STAGE_COUNT; k++) begin : g_stage
            assign lower_term[k+1] = lower_term[k] & stage_term[k];
            assign stage_step[k]   = count_ok & lower_term[k];

            cascade_counter_stage #(
                .P_STAGE_WIDTH (P_STAGE_WIDTH)
            ) u_stage (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .clear      (reset),
                .load       (load_act),
                .load_value (load_bus[k*P_STAGE_WIDTH +: P_STAGE_WIDTH]),
                .step       (stage_step[k]),
                .direction  (param_direction),
                .value      (counter[k*P_STAGE_WIDTH +: P_STAGE_WIDTH]),
                .terminal   (stage_term[k])
            );
        end
    endgenerate

    assign stage_carry   = stage_step & stage_term;
    assign counter_full  = &counter;
    assign counter_empty = ~(|counter);

    // A carry out of the top stage is a full-width wrap; flag it one cycle later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrap_pulse <= 1'b0;
        end else if (reset) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= stage_carry[P_STAGE_COUNT-1];
        end
    end

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter: a 2x2 and a 3x3 instance share stimulus and
// are checked against an arithmetic reference model one snapshot per cycle.
module tb_cascade_counter;

    logic       aclk;
    logic       aresetn;
    logic       reset;
    logic       en;
    logic       param_cycle_en;
    logic       param_direction;
    logic       load;
    logic [3:0] load_value;
    logic [8:0] load_value9;

    logic [3:0] counter;
    logic       counter_full, counter_empty, wrap_pulse, halted;
    logic [1:0] stage_carry;
    logic [8:0] counter9;
    logic       counter_full9, counter_empty9, wrap_pulse9, halted9;
    logic [2:0] stage_carry9;

    cascade_counter u_dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .reset           (reset),
        .en              (en),
        .param_cycle_en  (param_cycle_en),
        .param_direction (param_direction),
        .load            (load),
        .load_value      (load_value),
        .counter         (counter),
        .counter_full    (counter_full),
        .counter_empty   (counter_empty),
        .stage_carry     (stage_carry),
        .wrap_pulse      (wrap_pulse),
        .halted          (halted)
    );

    cascade_counter #(
        .P_STAGE_WIDTH (3),
        .P_STAGE_COUNT (3)
    ) u_dut9 (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .reset           (reset),
        .en              (en),
        .param_cycle_en  (param_cycle_en),
        .param_direction (param_direction),
        .load            (load),
        .load_value      (load_value9),
        .counter         (counter9),
        .counter_full    (counter_full9),
        .counter_empty   (counter_empty9),
        .stage_carry     (stage_carry9),
        .wrap_pulse      (wrap_pulse9),
        .halted          (halted9)
    );

    typedef struct {
        logic [3:0] c4;
        logic       w4, f4, e4, h4;
        logic [1:0] sc4;
        logic [8:0] c9;
        logic       w9, f9, e9, h9;
        logic [2:0] sc9;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    int m4 = 0, m9 = 0;
    bit mw4 = 0, mw9 = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit at_term(int cnt, int w, bit dir);
        return dir ? (cnt == (1 << w) - 1) : (cnt == 0);
    endfunction

    // Stage k rolls over when the low (k+1) digits are all at their terminal value.
    function automatic logic [7:0] carries(int cnt, int s, int c, bit dir, bit stepping);
        logic [7:0] r;
        int m;
        r = '0;
        for (int k = 0; k < c; k++) begin
            m = 1 << ((k + 1) * s);
            r[k] = stepping && (dir ? (cnt % m == m - 1) : (cnt % m == 0));
        end
        return r;
    endfunction

    function automatic int next_cnt(int cnt, int w, bit r, bit ld, int lv, bit st, bit dir);
        int m;
        m = 1 << w;
        if (r)  return 0;
        if (ld) return lv % m;
        if (st) return dir ? (cnt + 1) % m : (cnt + m - 1) % m;
        return cnt;
    endfunction

    task automatic do_cycle(input bit e, input bit r, input bit ld, input bit d, input bit cy,
                            input int lv4, input int lv9, input bit arst);
        snap_t s;
        bit ld_eff, st4, st9;
        logic [7:0] cr;
        @(negedge aclk);
        en = e; reset = r; load = ld; param_direction = d; param_cycle_en = cy;
        load_value = 4'(lv4); load_value9 = 9'(lv9);
        if (arst) begin
            #1 aresetn = 1'b0;
            m4 = 0; m9 = 0; mw4 = 0; mw9 = 0;
            #1 aresetn = 1'b1;
        end
`ifdef CASCADE_COUNTER_LOAD_EN
        ld_eff = ld;
`else
        ld_eff = 1'b0;
`endif
        s.h4 = !cy && at_term(m4, 4, d);
        s.h9 = !cy && at_term(m9, 9, d);
        st4 = e && !r && !ld_eff && !s.h4;
        st9 = e && !r && !ld_eff && !s.h9;
        s.c4 = 4'(m4); s.w4 = mw4; s.f4 = (m4 == 15);  s.e4 = (m4 == 0);
        s.c9 = 9'(m9); s.w9 = mw9; s.f9 = (m9 == 511); s.e9 = (m9 == 0);
        cr = carries(m4, 2, 2, d, st4); s.sc4 = cr[1:0];
        cr = carries(m9, 3, 3, d, st9); s.sc9 = cr[2:0];
        exp_q.push_back(s);
        mw4 = st4 && at_term(m4, 4, d);
        mw9 = st9 && at_term(m9, 9, d);
        m4 = next_cnt(m4, 4, r, ld_eff, lv4, st4, d);
        m9 = next_cnt(m9, 9, r, ld_eff, lv9, st9, d);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Monitor: one snapshot per cycle, sampled just before the next rising edge.
    initial begin
        snap_t s;
        forever begin
            @(negedge aclk);
            #4;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("counter",        32'(counter),        32'(s.c4));
                chk("wrap_pulse",     32'(wrap_pulse),     32'(s.w4));
                chk("counter_full",   32'(counter_full),   32'(s.f4));
                chk("counter_empty",  32'(counter_empty),  32'(s.e4));
                chk("halted",         32'(halted),         32'(s.h4));
                chk("stage_carry",    32'(stage_carry),    32'(s.sc4));
                chk("counter9",       32'(counter9),       32'(s.c9));
                chk("wrap_pulse9",    32'(wrap_pulse9),    32'(s.w9));
                chk("counter_full9",  32'(counter_full9),  32'(s.f9));
                chk("counter_empty9", 32'(counter_empty9), 32'(s.e9));
                chk("halted9",        32'(halted9),        32'(s.h9));
                chk("stage_carry9",   32'(stage_carry9),   32'(s.sc9));
            end
        end
    end

    initial begin
        bit d, cy;
        aresetn = 1'b0; reset = 1'b0; en = 1'b0; load = 1'b0;
        param_cycle_en = 1'b1; param_direction = 1'b1;
        load_value = '0; load_value9 = '0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        // Up with wrap across the full 4-bit range
        for (int i = 0; i < 17; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        // Down saturate from 2, then flip direction away from terminal
        do_cycle(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 0, 0, 0, 0);
        // Synchronous clear beats en at count 9
        do_cycle(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(1, 1, 0, 1, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        // Preload at count 4 overriding en
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(1, 0, 1, 1, 1, 13, 300, 0);
        do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        // Asynchronous reset mid-cycle at count 11, then resume counting
        do_cycle(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(1, 0, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        // Full 9-bit wrap on the 3x3 instance, then saturate at its top
        do_cycle(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 513; i++) do_cycle(1, 0, 0, 1, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 515; i++) do_cycle(1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0);

        d = 1'b1; cy = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) d = ~d;
            if ($urandom_range(19) == 0) cy = ~cy;
            do_cycle($urandom_range(3) != 0, $urandom_range(40) == 0,
                     $urandom_range(15) == 0, d, cy,
                     int'($urandom_range(15)), int'($urandom_range(511)),
                     $urandom_range(80) == 0);
        end
        do_cycle(0, 0, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge aclk);
        @(negedge aclk);
        #6;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
